// File: rtl/d_inst_buffer_pkg.sv
// d_inst_buffer_pkg: shared types, defaults and helpers for the decode-stage instruction buffer.
package d_inst_buffer_pkg;
    localparam int IB_DEPTH_DEFAULT = 8;
    localparam int IB_PRED_W = 32;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [IB_PRED_W-1:0] pred;
    } ib_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction
endpackage

// File: rtl/d_inst_buffer.sv
// d_inst_buffer: compacts 2-wide fetch packets into a per-instruction circular queue and
// presents the oldest 0/1/2 instructions to the dual-lane decoder as a left-aligned packet.
module d_inst_buffer
    import d_inst_buffer_pkg::*;
#(
    parameter int DEPTH  = IB_DEPTH_DEFAULT,
    parameter int PRED_W = IB_PRED_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       f_valid_i,
    output logic                       f_ready_o,
    input  logic [1:0]                 f_mask_i,
    input  logic [31:0]                f_pc_i,
    input  logic [1:0][31:0]           f_insts_i,
    input  logic [1:0][PRED_W-1:0]     f_pred_i,
    output logic                       d_valid_o,
    input  logic                       d_ready_i,
    output logic [1:0]                 d_mask_o,
    output logic [1:0][31:0]           d_pc_o,
    output logic [1:0][31:0]           d_insts_o,
    output logic [1:0][PRED_W-1:0]     d_pred_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     head, tail, head1, tail1;
    logic [AW:0]       count;
    logic [1:0]        n_in, n_out;
    logic              enq, deq;
    logic [31:0]       w0_pc, w0_inst;
    logic [PRED_W-1:0] w0_pred;

    logic [31:0]       pc_q   [DEPTH];
    logic [31:0]       inst_q [DEPTH];
    logic [PRED_W-1:0] pred_q [DEPTH];

    assign head1       = head + 1'b1;
    assign tail1       = tail + 1'b1;
    assign occupancy_o = count;
    assign f_ready_o   = count <= (AW+1)'(DEPTH - 2);
    assign d_valid_o   = count != '0;
    assign d_mask_o    = count >= (AW+1)'(2) ? 2'b11 : count == (AW+1)'(1) ? 2'b01 : 2'b00;
    assign enq         = f_valid_i & f_ready_o & ~flush_i;
    assign deq         = d_valid_o & d_ready_i & ~flush_i;
    assign n_in        = enq ? popcount2(f_mask_i) : 2'd0;
    assign n_out       = deq ? popcount2(d_mask_o) : 2'd0;

    // A lone lane1 instruction is compacted down into the tail slot with its own PC.
    assign w0_pc   = f_mask_i[0] ? f_pc_i : f_pc_i | 32'h4;
    assign w0_inst = f_mask_i[0] ? f_insts_i[0] : f_insts_i[1];
    assign w0_pred = f_mask_i[0] ? f_pred_i[0] : f_pred_i[1];

    always_comb begin
        d_pc_o[0]    = pc_q[head];
        d_pc_o[1]    = pc_q[head1];
        d_insts_o[0] = inst_q[head];
        d_insts_o[1] = inst_q[head1];
        d_pred_o[0]  = pred_q[head];
        d_pred_o[1]  = pred_q[head1];
    end

    always_ff @(posedge clk) begin
        if (n_in != 2'd0) begin
            pc_q[tail]   <= w0_pc;
            inst_q[tail] <= w0_inst;
            pred_q[tail] <= w0_pred;
        end
        if (n_in == 2'd2) begin
            pc_q[tail1]   <= f_pc_i | 32'h4;
            inst_q[tail1] <= f_insts_i[1];
            pred_q[tail1] <= f_pred_i[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_out);
            tail  <= tail + AW'(n_in);
            count <= count + (AW+1)'(n_in) - (AW+1)'(n_out);
        end
    end
endmodule

// File: tb/tb_d_inst_buffer.sv
// tb_d_inst_buffer: directed and randomized checks of d_inst_buffer against a queue-based model.
module tb_d_inst_buffer;
    import d_inst_buffer_pkg::*;

    logic             clk = 0;
    logic             rst = 1;
    logic             flush_i = 0;
    logic             f_valid_i = 0;
    logic             f_ready_o;
    logic [1:0]       f_mask_i = 0;
    logic [31:0]      f_pc_i = 0;
    logic [1:0][31:0] f_insts_i = '0;
    logic [1:0][31:0] f_pred_i = '0;
    logic             d_valid_o;
    logic             d_ready_i = 0;
    logic [1:0]       d_mask_o;
    logic [1:0][31:0] d_pc_o;
    logic [1:0][31:0] d_insts_o;
    logic [1:0][31:0] d_pred_o;
    logic [3:0]       occupancy_o;

    int checks = 0;
    int failures = 0;
    ib_entry_t q[$];

    d_inst_buffer dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .f_valid_i(f_valid_i), .f_ready_o(f_ready_o), .f_mask_i(f_mask_i),
        .f_pc_i(f_pc_i), .f_insts_i(f_insts_i), .f_pred_i(f_pred_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_mask_o(d_mask_o),
        .d_pc_o(d_pc_o), .d_insts_o(d_insts_o), .d_pred_o(d_pred_o),
        .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        int n = q.size();
        chk("d_valid", 64'(d_valid_o), 64'(n != 0));
        chk("d_mask", 64'(d_mask_o), n >= 2 ? 64'd3 : n == 1 ? 64'd1 : 64'd0);
        chk("f_ready", 64'(f_ready_o), 64'((8 - n) >= 2));
        chk("occupancy", 64'(occupancy_o), 64'(n));
        if (n >= 1) begin
            chk("pc0", 64'(d_pc_o[0]), 64'(q[0].pc));
            chk("inst0", 64'(d_insts_o[0]), 64'(q[0].inst));
            chk("pred0", 64'(d_pred_o[0]), 64'(q[0].pred));
        end
        if (n >= 2) begin
            chk("pc1", 64'(d_pc_o[1]), 64'(q[1].pc));
            chk("inst1", 64'(d_insts_o[1]), 64'(q[1].inst));
            chk("pred1", 64'(d_pred_o[1]), 64'(q[1].pred));
        end
    endtask

    // Called at a negedge: check, drive one cycle of stimulus, update the model across the edge.
    task automatic step(input logic fv, input logic [1:0] m, input logic [31:0] pc,
                        input logic dr, input logic fl);
        int n = q.size();
        int n_out;
        bit acc;
        compare_model();
        f_valid_i = fv; f_mask_i = m; f_pc_i = pc; d_ready_i = dr; flush_i = fl;
        f_insts_i = {$urandom, $urandom};
        f_pred_i  = {$urandom, $urandom};
        acc   = fv && (8 - n) >= 2;
        n_out = (dr && n > 0) ? (n >= 2 ? 2 : 1) : 0;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            for (int i = 0; i < n_out; i++) void'(q.pop_front());
            if (acc) for (int l = 0; l < 2; l++)
                if (m[l]) q.push_back('{pc: pc + 32'(4 * l), inst: f_insts_i[l], pred: f_pred_i[l]});
        end
        @(negedge clk);
        f_valid_i = 0; d_ready_i = 0; flush_i = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(d_valid_o), 64'd0);
        chk("reset_mask", 64'(d_mask_o), 64'd0);
        chk("reset_ready", 64'(f_ready_o), 64'd1);
        chk("reset_occ", 64'(occupancy_o), 64'd0);
        rst = 0;

        step(1, 2'b11, 32'h1C000000, 1, 0);
        chk("first_mask", 64'(d_mask_o), 64'd3);
        chk("first_pc0", 64'(d_pc_o[0]), 64'h1C000000);
        chk("first_pc1", 64'(d_pc_o[1]), 64'h1C000004);
        step(0, 2'b00, 0, 1, 0);
        chk("drained", 64'(occupancy_o), 64'd0);

        step(1, 2'b10, 32'h1C000008, 0, 0);
        chk("lane1_mask", 64'(d_mask_o), 64'd1);
        chk("lane1_pc", 64'(d_pc_o[0]), 64'h1C00000C);
        chk("lane1_occ", 64'(occupancy_o), 64'd1);
        step(0, 2'b00, 0, 0, 1);

        for (int i = 0; i < 4; i++) step(1, 2'b11, 32'h2000 + 32'(8 * i), 0, 0);
        chk("full_occ", 64'(occupancy_o), 64'd8);
        chk("full_ready", 64'(f_ready_o), 64'd0);
        step(1, 2'b11, 32'h3000, 0, 0);
        step(0, 2'b00, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 2'b11, 32'h4000 + 32'(8 * i), 0, 0);
        step(1, 2'b01, 32'h4018, 0, 0);
        chk("seven_occ", 64'(occupancy_o), 64'd7);
        chk("seven_ready", 64'(f_ready_o), 64'd0);

        // Drain to head=tail=7, then straddle the wrap with a 2-lane packet.
        for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 1, 0);
        chk("wrap_empty", 64'(occupancy_o), 64'd0);
        step(1, 2'b11, 32'h5000, 0, 0);
        chk("wrap_pc1", 64'(d_pc_o[1]), 64'h5004);
        step(0, 2'b00, 0, 1, 0);

        step(1, 2'b11, 32'h6000, 0, 0);
        step(1, 2'b11, 32'h6008, 0, 0);
        chk("pre_flush_occ", 64'(occupancy_o), 64'd4);
        step(1, 2'b11, 32'h6010, 1, 1);
        chk("flush_occ", 64'(occupancy_o), 64'd0);
        chk("flush_valid", 64'(d_valid_o), 64'd0);
        chk("flush_ready", 64'(f_ready_o), 64'd1);

        step(1, 2'b11, 32'h7000, 0, 0);
        step(1, 2'b01, 32'h7008, 0, 0);
        step(1, 2'b01, 32'h7010, 1, 0);
        chk("simul_occ", 64'(occupancy_o), 64'd2);
        f_valid_i = 1; f_mask_i = 2'b11; d_ready_i = 1;
        rst = 1;
        #1;
        q.delete();
        chk("async_rst_occ", 64'(occupancy_o), 64'd0);
        chk("async_rst_valid", 64'(d_valid_o), 64'd0);
        @(negedge clk);
        rst = 0;
        f_valid_i = 0; d_ready_i = 0;

        for (int i = 0; i < 400; i++)
            step($urandom_range(3) != 0, 2'($urandom), $urandom & 32'hFFFF_FFF8,
                 $urandom_range(2) != 0, $urandom_range(29) == 0);
        compare_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
